// File: rtl/sr_latch_driver.sv
// Sequencer that drives an external SR latch through setup/strobe/release,
// then checks the latch feedback and reports the result with a done pulse.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       q_fb,
    input  logic       qbar_fb,
    output logic       S,
    output logic       R,
    output logic       En,
    output logic       done,
    output logic [1:0] err_code,
    output logic [7:0] fail_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] CHECK   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [3:0] STROBE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [2:0] state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       exp_q, exp_n;
    logic [1:0] res;
    logic       drive_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        exp_n   = exp_q;
        res     = (q_fb == qbar_fb) ? 2'b10 : (q_fb != exp_q) ? 2'b01 : 2'b00;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = SETUP;
                    case (cmd_op)
                        2'b00:   state_n = DONE;
                        2'b01:   exp_n = 1'b0;
                        2'b10:   exp_n = 1'b1;
                        default: exp_n = ~q_fb;
                    endcase
                end
            end
            SETUP: begin
                state_n = STROBE;
                cnt_n   = STROBE_LAST;
            end
            STROBE: begin
                if (cnt == 4'd0) state_n = RELEASE;
                else             cnt_n = cnt - 4'd1;
            end
            RELEASE: begin
                state_n = CHECK;
                cnt_n   = SETTLE_LAST;
            end
            CHECK: begin
                if (cnt == 4'd0) state_n = DONE;
                else             cnt_n = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
        drive_n = (state_n == SETUP) || (state_n == STROBE) || (state_n == RELEASE);
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            exp_q     <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            En        <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            err_code  <= 2'b00;
            fail_cnt  <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            exp_q     <= exp_n;
            S         <= drive_n & exp_n;
            R         <= drive_n & ~exp_n;
            En        <= (state_n == STROBE);
            done      <= (state_n == DONE);
            cmd_ready <= (state_n == IDLE);
            if (state_n == DONE) begin
                // A NOP enters DONE straight from IDLE and always reports ok.
                err_code <= (state == CHECK) ? res : 2'b00;
                if (state == CHECK && res != 2'b00 && fail_cnt != 8'hFF)
                    fail_cnt <= fail_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch on the drive pins.
module tb_sr_latch_driver;

    localparam int PW = 2;
    localparam int ST = 1;
    localparam int LAT = PW + ST + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, S, R, En, done;
    logic       q_fb, qbar_fb;
    logic [1:0] err_code;
    logic [7:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    // latch model: follows S/R while En is high; mode 1 = stuck q=0, mode 2 = both high
    logic       lq = 1'b0;
    logic       preset_en = 1'b0;
    logic       preset_val = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       inv_bad = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preset_en)      lq <= preset_val;
        else if (En && S)   lq <= 1'b1;
        else if (En && R)   lq <= 1'b0;
    end

    assign q_fb    = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : lq;
    assign qbar_fb = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b1 : ~lq;

    always @(negedge clk) if (S && R) inv_bad <= 1'b1;

    sr_latch_driver #(.PULSE_W(PW), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .q_fb(q_fb), .qbar_fb(qbar_fb),
        .S(S), .R(R), .En(En), .done(done), .err_code(err_code), .fail_cnt(fail_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic preset(input logic v);
        @(negedge clk);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Issue one command; lat counts cycles from the accept edge to the done cycle.
    task automatic run_cmd(input logic [1:0] op, output int lat, output int en_c,
                           output int s_c, output int r_c);
        int w;
        lat = 0; en_c = 0; s_c = 0; r_c = 0;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            en_c += int'(En);
            s_c  += int'(S);
            r_c  += int'(R);
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       init_q;
        logic [1:0] mode;
        logic [1:0] exp_err;
        logic       exp_q;
        int         exp_lat;
        int         exp_en;
        int         exp_s;
        int         exp_r;
    } vec_t;

    vec_t vecs[8];
    int   exp_fail;

    initial begin
        int lat, en_c, s_c, r_c, n_done;
        logic [1:0] ec;

        vecs[0] = '{2'b10, 1'b0, 2'd0, 2'b00, 1'b1, LAT, PW, PW + 2, 0};
        vecs[1] = '{2'b01, 1'b1, 2'd0, 2'b00, 1'b0, LAT, PW, 0, PW + 2};
        vecs[2] = '{2'b11, 1'b1, 2'd0, 2'b00, 1'b0, LAT, PW, 0, PW + 2};
        vecs[3] = '{2'b11, 1'b0, 2'd0, 2'b00, 1'b1, LAT, PW, PW + 2, 0};
        vecs[4] = '{2'b10, 1'b0, 2'd1, 2'b01, 1'b0, LAT, PW, PW + 2, 0};
        vecs[5] = '{2'b01, 1'b0, 2'd2, 2'b10, 1'b1, LAT, PW, 0, PW + 2};
        vecs[6] = '{2'b00, 1'b1, 2'd0, 2'b00, 1'b1, 1, 0, 0, 0};
        vecs[7] = '{2'b10, 1'b1, 2'd0, 2'b00, 1'b1, LAT, PW, PW + 2, 0};

        repeat (3) @(negedge clk);
        chk("rst_S", int'(S), 0);
        chk("rst_En", int'(En), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_code), 0);
        chk("rst_fail", int'(fail_cnt), 0);

        exp_fail = 0;
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            preset(vecs[i].init_q);
            run_cmd(vecs[i].op, lat, en_c, s_c, r_c);
            ec = err_code;
            if (vecs[i].exp_err != 2'b00 && exp_fail < 255) exp_fail++;
            chk($sformatf("v%0d_err", i), int'(ec), int'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_en", i), en_c, vecs[i].exp_en);
            chk($sformatf("v%0d_s", i), s_c, vecs[i].exp_s);
            chk($sformatf("v%0d_r", i), r_c, vecs[i].exp_r);
            chk($sformatf("v%0d_q", i), int'(q_fb), int'(vecs[i].exp_q));
            chk($sformatf("v%0d_fail", i), int'(fail_cnt), exp_fail);
            @(negedge clk);
            chk($sformatf("v%0d_ready_b2b", i), int'(cmd_ready), 1);
            chk($sformatf("v%0d_err_hold", i), int'(err_code), int'(vecs[i].exp_err));
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
        end

        // cmd_valid held through a busy command must not queue a second one
        mode = 2'd0;
        preset(1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(negedge clk);
        cmd_op = 2'b00;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        chk("busy_lat", lat, LAT);
        n_done = 0;
        repeat (5) begin
            @(negedge clk);
            n_done += int'(done);
        end
        chk("busy_no_extra_done", n_done, 0);

        // saturation: 256 mismatching SETs
        mode = 2'd1;
        for (int k = 0; k < 256; k++) begin
            run_cmd(2'b10, lat, en_c, s_c, r_c);
            if (exp_fail < 255) exp_fail++;
        end
        chk("sat_err", int'(err_code), 1);
        chk("sat_fail", int'(fail_cnt), 255);
        chk("sat_model", exp_fail, 255);

        // reset during STROBE
        mode = 2'd0;
        preset(1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!En && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_in_strobe", int'(En), 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_En", int'(En), 0);
        chk("abort_S", int'(S), 0);
        chk("abort_R", int'(R), 0);
        chk("abort_fail", int'(fail_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            n_done += int'(done);
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_fail_after", int'(fail_cnt), 0);
        run_cmd(2'b10, lat, en_c, s_c, r_c);
        chk("post_abort_lat", lat, LAT);
        chk("post_abort_err", int'(err_code), 0);
        chk("post_abort_q", int'(q_fb), 1);

        chk("invariant_s_and_r", int'(inv_bad), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
